// File: rtl/frame_buffer_pkg.sv
// Purpose  : shared write-FSM encoding and depth/address-width helpers for the ping-pong frame store.
// Latency  : n/a (types and constant functions only).
// Backpress: n/a.
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  // Ceiling log2, never below 1 so a one-word frame still gets an address bit.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

  function automatic int fb_depth(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

  function automatic int fb_addr_w(input int h_res, input int v_res);
    return clog2(h_res * v_res);
  endfunction

endpackage

// File: rtl/frame_buffer_pingpong_if.sv
// Purpose  : camera-write / display-read bundle of the ping-pong frame store, plus its status outputs.
// Latency  : n/a (wiring only).
// Backpress: none; both sides are strobe-driven, no ready signals.
// Ports    : master = capture + display logic (drives wr_*, rd_sof, rd_en); slave = frame store.
interface frame_buffer_pingpong_if #(
  parameter int PIX_W = 12,
  parameter int CNT_W = 16
);
  logic             wr_sof;
  logic             wr_en;
  logic             cmos_pixel_valid;
  logic [PIX_W-1:0] wr_data;
  logic             rd_sof;
  logic             rd_en;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             frame_ready;
  logic             wr_buf;
  logic             rd_buf;
  logic [CNT_W-1:0] drop_cnt;
  logic             frame_err;

  modport master (
    output wr_sof, wr_en, cmos_pixel_valid, wr_data, rd_sof, rd_en,
    input  rd_data, rd_valid, frame_ready, wr_buf, rd_buf, drop_cnt, frame_err
  );

  modport slave (
    input  wr_sof, wr_en, cmos_pixel_valid, wr_data, rd_sof, rd_en,
    output rd_data, rd_valid, frame_ready, wr_buf, rd_buf, drop_cnt, frame_err
  );
endinterface

// File: rtl/fb_dp_ram.sv
// Purpose  : simple dual-port RAM, one write port and one registered read port (BRAM style).
// Latency  : read data appears 1 cycle after re_i; a write is readable the cycle after it.
// Backpress: none.
// Ports    : clk/rst_n; we_i/waddr_i/wdata_i write port; re_i/raddr_i read port; rdata_o registered data.
module fb_dp_ram #(
  parameter int PIX_W = 12,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  // Sized to the full {buf,addr} space so a non-power-of-two frame maps without translation.
  logic [PIX_W-1:0] mem [2**AW];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; array contents stay undefined until written.
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Purpose  : double-buffered frame store; camera fills one buffer while the display reads the other.
// Latency  : rd_data/rd_valid 1 cycle after rd_en; frame_ready 1 cycle after the last pixel write.
// Backpress: none; pixels are never stalled, an undisplayed frame is overwritten and counted in drop_cnt.
// Ports    : clk, rst_n (sync, active low); bus = frame_buffer_pingpong_if slave (write, read, status).
module frame_buffer_pingpong
  import frame_buffer_pkg::*;
#(
  parameter int               PIX_W = 12,
  parameter int               H_RES = 640,
  parameter int               V_RES = 480,
  parameter logic [PIX_W-1:0] FILL  = '0,
  parameter int               CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  frame_buffer_pingpong_if.slave   bus
);

  localparam int                DEPTH  = fb_depth(H_RES, V_RES);
  localparam int                ADDR_W = fb_addr_w(H_RES, V_RES);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_buf_q, wr_buf_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              frame_err_q, frame_err_d;
  logic              rd_valid_q;

  logic              swap;
  logic              ram_we;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_buf_nxt;
  logic [PIX_W-1:0]  ram_wdata;

  // A swap needs a finished frame and a display start-of-frame in the same cycle.
  assign swap = (state_q == ST_DONE) && bus.rd_sof;

  // wr_sof restarts the frame in the same cycle, so a coincident wr_en lands on address 0.
  assign wr_ptr    = bus.wr_sof ? '0 : wr_addr_q;
  assign ram_wdata = bus.cmos_pixel_valid ? bus.wr_data : FILL;

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_buf_d    = wr_buf_q;
    drop_d      = drop_q;
    frame_err_d = 1'b0;
    ram_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.wr_sof) begin
          state_d   = ST_WRITE;
          wr_addr_d = '0;
        end
      end
      ST_WRITE: begin
        frame_err_d = bus.wr_sof;
        if (bus.wr_sof) wr_addr_d = '0;
        if (bus.wr_en) begin
          ram_we = 1'b1;
          if (wr_ptr == LAST) begin
            state_d   = ST_DONE;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_ptr + ADDR_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (swap) begin
          // Swap wins over a coincident wr_sof: nothing is dropped, writing resumes on the freed buffer.
          wr_buf_d  = ~wr_buf_q;
          state_d   = bus.wr_sof ? ST_WRITE : ST_IDLE;
          wr_addr_d = '0;
        end else if (bus.wr_sof) begin
          if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
          state_d   = ST_WRITE;
          wr_addr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read side uses the post-swap buffer so rd_sof+rd_en already fetches the new frame.
  assign rd_buf_nxt = ~wr_buf_d;
  assign rd_ptr     = bus.rd_sof ? '0 : rd_addr_q;

  always_comb begin
    rd_addr_d = rd_addr_q;
    if (bus.rd_en)       rd_addr_d = (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_W'(1);
    else if (bus.rd_sof) rd_addr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_buf_q    <= 1'b0;
      drop_q      <= '0;
      frame_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_buf_q    <= wr_buf_d;
      drop_q      <= drop_d;
      frame_err_q <= frame_err_d;
      rd_valid_q  <= bus.rd_en;
    end
  end

  fb_dp_ram #(
    .PIX_W (PIX_W),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ram_we),
    .waddr_i ({wr_buf_q, wr_ptr}),
    .wdata_i (ram_wdata),
    .re_i    (bus.rd_en),
    .raddr_i ({rd_buf_nxt, rd_ptr}),
    .rdata_o (bus.rd_data)
  );

  // rd_buf is derived from wr_buf so the two can never point at the same buffer.
  assign bus.frame_ready = (state_q == ST_DONE);
  assign bus.wr_buf      = wr_buf_q;
  assign bus.rd_buf      = ~wr_buf_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.rd_valid    = rd_valid_q;

endmodule

// File: doc/frame_buffer_pingpong.md
# frame_buffer_pingpong

Parametrised, single-clock, double-buffered frame store for the camera-to-display path. Camera pixels are written into one frame buffer while the display reads a second, complete frame. The two buffers swap only at a read start-of-frame and only when a fully written frame is waiting, so the display never shows a torn frame. It sits between the CMOS capture logic and the VGA read-out logic.

## Interface
- PIX_W, 12: pixel width in bits
- H_RES, 640: pixels per line
- V_RES, 480: lines per frame
- FILL, 0: value written when a write slot carries an invalid pixel
- CNT_W, 16: width of the dropped-frame counter
- clk  in  1  single clock for both ports
- rst_n  in  1  synchronous, active-low reset
- wr_sof  in  1  write start-of-frame pulse
- wr_en  in  1  write slot strobe
- cmos_pixel_valid  in  1  qualifies wr_data; 0 writes FILL
- wr_data  in  PIX_W  pixel to store
- rd_sof  in  1  read start-of-frame pulse
- rd_en  in  1  read strobe
- rd_data  out  PIX_W  read pixel, valid one cycle after rd_en
- rd_valid  out  1  qualifies rd_data
- frame_ready  out  1  a completed frame is waiting for a swap
- wr_buf  out  1  index of the buffer being written
- rd_buf  out  1  index of the buffer being read
- drop_cnt  out  CNT_W  completed frames overwritten before being displayed (saturating)
- frame_err  out  1  one-cycle pulse on a short frame

## Operation
- DEPTH = H_RES*V_RES; ADDR_W = clog2(DEPTH). Storage is 2*DEPTH words; physical address = {buf, addr}.
- Write FSM states:
  - IDLE: wait for wr_sof, which sets wr_addr=0 and moves to WRITE.
  - WRITE: each wr_en writes mem[{wr_buf,wr_addr}] <= cmos_pixel_valid ? wr_data : FILL, then wr_addr++. The write at wr_addr=DEPTH-1 moves to DONE.
  - DONE: frame_ready=1.
- wr_en outside WRITE is ignored.
- wr_sof in WRITE: pulse frame_err, set wr_addr=0, stay in WRITE. A same-cycle wr_en writes address 0.
- wr_sof in DONE without a same-cycle swap: increment drop_cnt, saturating at 2^CNT_W-1. Then set wr_addr=0 and go to WRITE; the waiting frame is overwritten.
- Swap: rd_sof while in DONE swaps wr_buf and rd_buf and sets the FSM to IDLE.
  - Same-cycle wr_sof: the swap takes priority, drop_cnt is not incremented, and the FSM enters WRITE on the new wr_buf.
- Read port:
  - rd_sof sets rd_addr=0, applied after any swap.
  - rd_en reads mem[{rd_buf,rd_addr}] and increments rd_addr, wrapping from DEPTH-1 to 0.
  - rd_sof and rd_en in the same cycle read address 0 of the post-swap rd_buf; rd_addr then becomes 1.
- Invariant: wr_buf != rd_buf at all times.

## Timing
- Reset values: state IDLE, wr_addr=0, rd_addr=0, wr_buf=0, rd_buf=1, frame_ready=0, drop_cnt=0, frame_err=0, rd_data=0, rd_valid=0.
- Memory contents are not reset. Reads before the first swap return undefined data.
- Read latency is 1: rd_valid(t+1) = rd_en(t).
- A write is visible to the read port one cycle after it; there is no cross-buffer hazard because the buffers never overlap.
- frame_ready rises in the cycle after the last write and falls in the cycle after the swap, or after an overwriting wr_sof.
- Reset asserted mid-frame aborts the frame; post-reset behaviour is identical to power-up.

## Structure
- Shared package frame_buffer_pkg holds:
  - the write-FSM state encoding (IDLE, WRITE, DONE);
  - a clog2 function;
  - the DEPTH/ADDR_W derivation.
- Sub-module fb_dp_ram: a simple dual-port RAM (one write port, one registered read port) with parameters PIX_W and AW = ADDR_W+1, inferred as BRAM.
- The controller holds the FSM, both address counters, buffer indices and drop counter.

## Test plan
Use H_RES=4, V_RES=2, PIX_W=12.
- Reset: pulse rst_n=0 -> frame_ready=0, wr_buf=0, rd_buf=1, drop_cnt=0, rd_valid=0 in the cycle after release.
- Frame write and read:
  - wr_sof, then 8 wr_en with data 1..8, all valid -> frame_ready=1 after the 8th write.
  - rd_sof -> wr_buf=1, rd_buf=0.
  - 8 rd_en -> rd_data 1..8, each one cycle later.
  - A 9th rd_en returns 1 (address wrap).
- Invalid pixels: frame with cmos_pixel_valid=0 on pixels 3 and 6 and FILL=0 -> after swap, reads 1,2,0,4,5,0,7,8.
- Drop: complete frame A, then wr_sof with no rd_sof -> drop_cnt=1, frame_ready=0. Complete frame B, then swap -> reads return B.
- Simultaneous swap: wr_sof and rd_sof in the same cycle while in DONE -> buffers swap, drop_cnt unchanged, writes go to the new wr_buf.
- Short frame: wr_sof after 5 writes -> one-cycle frame_err, wr_addr restarts at 0, frame_ready stays 0 until 8 further writes complete.
